// File: rtl/alu_flags_unit_if.sv
// Bus between an ALU flag consumer and alu_flags_unit: capture, save/restore
// pulses, the four-phase condition query and the held state.
interface alu_flags_unit_if;
    logic       resultValid;
    logic [7:0] result;
    logic       isZero;
    logic       sign;
    logic       unsignedOverflow;
    logic       overflow;
    logic       isAdding;
    logic       saveFlags;
    logic       restoreFlags;
    logic       condReq;
    logic [2:0] condCode;
    logic [7:0] heldResult;
    logic [4:0] flags;
    logic [4:0] shadowFlags;
    logic       condAck;
    logic       condTrue;

    modport master (
        output resultValid, result, isZero, sign, unsignedOverflow, overflow, isAdding,
        output saveFlags, restoreFlags, condReq, condCode,
        input  heldResult, flags, shadowFlags, condAck, condTrue
    );

    modport slave (
        input  resultValid, result, isZero, sign, unsignedOverflow, overflow, isAdding,
        input  saveFlags, restoreFlags, condReq, condCode,
        output heldResult, flags, shadowFlags, condAck, condTrue
    );
endinterface

// File: rtl/alu_flags_unit.sv
// Holds the last ALU result and its flags {Z,N,C,V,A}, a one-deep shadow copy,
// and answers four-phase condition-code queries against the flags.
module alu_flags_unit (
    input logic             clk,
    input logic             reset,
    alu_flags_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACK, RELEASE} condState_t;

    localparam logic [4:0] FLAGS_RST = 5'b10000;

    condState_t condState;
    logic [7:0] heldResultQ;
    logic [4:0] flagsQ;
    logic [4:0] shadowQ;
    logic [4:0] aluFlags;
    logic [4:0] flagsNext;
    logic       condAckQ;
    logic       condTrueQ;

    assign aluFlags = {bus.isZero, bus.sign, bus.unsignedOverflow, bus.overflow, bus.isAdding};

    // Capture wins over restore; this value also feeds the query so a request
    // landing on the same edge as a flag update sees the new flags.
    always_comb begin
        flagsNext = flagsQ;
        if (bus.resultValid)
            flagsNext = aluFlags;
        else if (bus.restoreFlags)
            flagsNext = shadowQ;
    end

    function automatic logic evalCond(input logic [2:0] code, input logic [4:0] f);
        logic z, n, c, v, a;
        {z, n, c, v, a} = f;
        case (code)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n ^ v;
            3'd4:    return !(n ^ v);
            3'd5:    return c & !a;
            3'd6:    return !(c & !a);
            default: return v;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            heldResultQ <= 8'h00;
            flagsQ      <= FLAGS_RST;
            shadowQ     <= FLAGS_RST;
            condState   <= IDLE;
            condAckQ    <= 1'b0;
            condTrueQ   <= 1'b0;
        end else begin
            if (bus.resultValid)
                heldResultQ <= bus.result;
            flagsQ <= flagsNext;
            // Shadow always takes the pre-edge flags, which makes save+restore a swap.
            if (bus.saveFlags)
                shadowQ <= flagsQ;

            case (condState)
                IDLE: begin
                    if (bus.condReq) begin
                        condTrueQ <= evalCond(bus.condCode, flagsNext);
                        condAckQ  <= 1'b1;
                        condState <= ACK;
                    end
                end
                ACK: begin
                    if (!bus.condReq) begin
                        condAckQ  <= 1'b0;
                        condTrueQ <= 1'b0;
                        condState <= RELEASE;
                    end
                end
                default: begin
                    condState <= IDLE;
                end
            endcase
        end
    end

    assign bus.heldResult  = heldResultQ;
    assign bus.flags       = flagsQ;
    assign bus.shadowFlags = shadowQ;
    assign bus.condAck     = condAckQ;
    assign bus.condTrue    = condTrueQ;
endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed bench for alu_flags_unit: register checks inline, condition-query
// responses through an expected-value queue drained by a separate monitor.
module tb_alu_flags_unit;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic expQ[$];
    bit   done = 1'b0;

    alu_flags_unit_if bus ();

    alu_flags_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack rising edge must match the oldest outstanding query.
    initial begin : monitor
        logic ackPrev;
        logic e;
        ackPrev = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.condAck === 1'b1 && ackPrev !== 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with no query outstanding");
                end else begin
                    e = expQ.pop_front();
                    check("condTrue", {7'd0, bus.condTrue}, {7'd0, e});
                end
            end
            if (bus.condAck === 1'b0 && bus.condTrue !== 1'b0)
                check("condTrue_idle_zero", {7'd0, bus.condTrue}, 8'd0);
            ackPrev = bus.condAck;
        end
    end

    task automatic idleInputs();
        bus.resultValid = 0; bus.result = 8'h00;
        {bus.isZero, bus.sign, bus.unsignedOverflow, bus.overflow, bus.isAdding} = 5'b0;
        bus.saveFlags = 0; bus.restoreFlags = 0;
        bus.condReq = 0; bus.condCode = 3'd0;
    endtask

    task automatic capture(input logic [7:0] res, input logic [4:0] f);
        @(negedge clk);
        bus.resultValid = 1; bus.result = res;
        {bus.isZero, bus.sign, bus.unsignedOverflow, bus.overflow, bus.isAdding} = f;
        @(negedge clk);
        bus.resultValid = 0;
    endtask

    task automatic pulse(input logic sv, input logic rs);
        @(negedge clk);
        bus.saveFlags = sv; bus.restoreFlags = rs;
        @(negedge clk);
        bus.saveFlags = 0; bus.restoreFlags = 0;
    endtask

    // Full handshake: request, hold for `hold` ack cycles, release, wait out RELEASE.
    task automatic query(input logic [2:0] code, input logic exp, input int hold);
        @(negedge clk);
        bus.condReq = 1; bus.condCode = code;
        expQ.push_back(exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_held", {7'd0, bus.condAck}, 8'd1);
            bus.condCode = ~code;
        end
        bus.condReq = 0;
        @(negedge clk);
        check("ack_release", {7'd0, bus.condAck}, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        reset = 1;
        // Reset must beat every other input.
        bus.resultValid = 1; bus.result = 8'hAA; bus.sign = 1;
        bus.saveFlags = 1; bus.restoreFlags = 1; bus.condReq = 1;
        repeat (2) @(negedge clk);
        check("rst_held", bus.heldResult, 8'h00);
        check("rst_flags", {3'd0, bus.flags}, 8'h10);
        check("rst_shadow", {3'd0, bus.shadowFlags}, 8'h10);
        check("rst_ack", {7'd0, bus.condAck}, 8'd0);
        idleInputs();
        reset = 0;
        @(negedge clk);

        // 30 with A=1
        capture(8'd30, 5'b00001);
        check("cap30_held", bus.heldResult, 8'd30);
        check("cap30_flags", {3'd0, bus.flags}, 8'h01);
        query(3'd1, 1'b0, 1);
        query(3'd2, 1'b1, 1);

        // 5-25 = 0xEC, N=1 C=1
        capture(8'hEC, 5'b01100);
        check("sub_flags", {3'd0, bus.flags}, 8'h0C);
        query(3'd3, 1'b1, 1);
        query(3'd5, 1'b1, 1);
        query(3'd6, 1'b0, 1);
        query(3'd4, 1'b0, 1);
        query(3'd7, 1'b0, 1);
        query(3'd0, 1'b1, 1);

        // Save / restore
        capture(8'h00, 5'b10000);
        pulse(1, 0);
        check("save_shadow", {3'd0, bus.shadowFlags}, 8'h10);
        capture(8'h80, 5'b01000);
        check("capN_flags", {3'd0, bus.flags}, 8'h08);
        pulse(0, 1);
        check("restore_flags", {3'd0, bus.flags}, 8'h10);
        check("restore_held", bus.heldResult, 8'h80);
        capture(8'h81, 5'b01000);
        pulse(1, 1);
        check("swap_flags", {3'd0, bus.flags}, 8'h10);
        check("swap_shadow", {3'd0, bus.shadowFlags}, 8'h08);
        check("swap_held", bus.heldResult, 8'h81);

        // Capture beats restore; save takes pre-edge flags
        @(negedge clk);
        bus.resultValid = 1; bus.result = 8'h11;
        {bus.isZero, bus.sign, bus.unsignedOverflow, bus.overflow, bus.isAdding} = 5'b00110;
        bus.saveFlags = 1; bus.restoreFlags = 1;
        @(negedge clk);
        idleInputs();
        check("prio_flags", {3'd0, bus.flags}, 8'h06);
        check("prio_shadow", {3'd0, bus.shadowFlags}, 8'h10);
        check("prio_held", bus.heldResult, 8'h11);

        // Forwarding: request on the same edge as Z capture
        @(negedge clk);
        bus.resultValid = 1; bus.result = 8'h00; bus.isZero = 1;
        bus.condReq = 1; bus.condCode = 3'd1;
        expQ.push_back(1'b1);
        @(negedge clk);
        check("fwd_ack", {7'd0, bus.condAck}, 8'd1);
        // Frozen: clearing Z while acked must not move condTrue
        bus.result = 8'h05; bus.isZero = 0;
        @(negedge clk);
        bus.resultValid = 0;
        check("frozen_true", {7'd0, bus.condTrue}, 8'd1);
        check("frozen_flags", {3'd0, bus.flags}, 8'h00);
        bus.condReq = 0;
        repeat (2) @(negedge clk);

        // Long hold, then re-request during RELEASE
        query(3'd2, 1'b1, 5);
        @(negedge clk);
        bus.condReq = 1; bus.condCode = 3'd1;
        expQ.push_back(1'b0);
        @(negedge clk);
        check("rel_ack1", {7'd0, bus.condAck}, 8'd1);
        bus.condReq = 0;
        @(negedge clk);
        check("rel_ack0", {7'd0, bus.condAck}, 8'd0);
        bus.condReq = 1;
        expQ.push_back(1'b0);
        @(negedge clk);
        check("rel_not_sampled", {7'd0, bus.condAck}, 8'd0);
        @(negedge clk);
        check("rel_reacked", {7'd0, bus.condAck}, 8'd1);
        bus.condReq = 0;
        repeat (2) @(negedge clk);

        // Reset during ACK, request still high afterwards
        @(negedge clk);
        bus.condReq = 1; bus.condCode = 3'd2;
        expQ.push_back(1'b1);
        @(negedge clk);
        check("pre_rst_ack", {7'd0, bus.condAck}, 8'd1);
        reset = 1;
        @(negedge clk);
        check("mid_rst_ack", {7'd0, bus.condAck}, 8'd0);
        check("mid_rst_held", bus.heldResult, 8'h00);
        check("mid_rst_flags", {3'd0, bus.flags}, 8'h10);
        bus.condCode = 3'd1;
        expQ.push_back(1'b1);
        reset = 0;
        @(negedge clk);
        check("post_rst_ack", {7'd0, bus.condAck}, 8'd1);
        bus.condReq = 0;
        repeat (3) @(negedge clk);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL pending_queries: got %0d outstanding expected 0", expQ.size());
        end
        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
